// File: rtl/mario_cen_pkg.sv
// Shared constants for the fractional clock-enable generator: default widths
// and the standard NUM/DEN pairs for rates derived from the 48 MHz master clock.
package mario_cen_pkg;

  localparam int CEN_ACC_W = 8;
  localparam int MAX_CH    = 16;

  typedef struct packed {
    logic [15:0] num;
    logic [15:0] den;
  } cen_rate_t;

  localparam cen_rate_t CEN_24M = '{num: 16'd1,  den: 16'd2};
  localparam cen_rate_t CEN_12M = '{num: 16'd1,  den: 16'd4};
  localparam cen_rate_t CEN_6M  = '{num: 16'd1,  den: 16'd8};
  localparam cen_rate_t CEN_4M  = '{num: 16'd1,  den: 16'd12};
  localparam cen_rate_t CEN_11M = '{num: 16'd11, den: 16'd48};

endpackage

// File: rtl/mario_cen_if.sv
// Control/config inputs and enable outputs of mario_cen_gen, bundled so a
// board top can route one connection to every consumer of the enables.
interface mario_cen_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 8
);
  logic                      I_EN;
  logic                      I_SYNC;
  logic [NUM_CH*ACC_W-1:0]   I_NUM;
  logic [NUM_CH*ACC_W-1:0]   I_DEN;
  logic [NUM_CH-1:0]         O_CEN_P;
  logic [NUM_CH-1:0]         O_CEN_N;
  logic [NUM_CH-1:0]         O_ACTIVE;

  modport master (
    output I_EN, I_SYNC, I_NUM, I_DEN,
    input  O_CEN_P, O_CEN_N, O_ACTIVE
  );

  modport slave (
    input  I_EN, I_SYNC, I_NUM, I_DEN,
    output O_CEN_P, O_CEN_N, O_ACTIVE
  );
endinterface

// File: rtl/mario_cen_chan.sv
// One fractional phase-accumulator enable channel (rate = NUM/DEN * f_clk).
// Negative-phase pulse is only built when MARIO_CEN_NEG_EN is defined.
import mario_cen_pkg::*;

module mario_cen_chan #(
  parameter int ACC_W = CEN_ACC_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic [ACC_W-1:0] i_num,
  input  logic [ACC_W-1:0] i_den,
  output logic             o_cen_p,
  output logic             o_cen_n,
  output logic             o_active
);

  logic [ACC_W-1:0] r_acc;
  logic             r_cen_p;
  logic             r_active;

  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_sum_sub;
  logic             w_wrap;
  logic [ACC_W-1:0] w_frac_acc;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_frac;
  logic             w_cen_p_next;
  logic             w_active_next;

  assign w_sum      = {1'b0, r_acc} + {1'b0, i_num};
  assign w_sum_sub  = w_sum - {1'b0, i_den};
  assign w_wrap     = (w_sum >= {1'b0, i_den});
  // In the fractional branch acc<DEN and NUM<DEN, so sum-DEN always fits ACC_W.
  assign w_frac_acc = w_wrap ? w_sum_sub[ACC_W-1:0] : w_sum[ACC_W-1:0];

  always_comb begin
    w_frac        = 1'b0;
    w_acc_base    = r_acc;
    w_cen_p_next  = 1'b0;
    w_active_next = (i_den != '0) && i_en;
    if (i_sync) begin
      w_acc_base = '0;
    end else if (i_den == '0) begin
      w_acc_base = '0;
    end else if (!i_en) begin
      w_acc_base = r_acc;
    end else if (i_num >= i_den) begin
      w_acc_base   = '0;
      w_cen_p_next = 1'b1;
    end else if (r_acc >= i_den) begin
      // DEN dropped below the running phase: emit one pulse and restart.
      w_acc_base   = '0;
      w_cen_p_next = 1'b1;
    end else begin
      w_frac       = 1'b1;
      w_cen_p_next = w_wrap;
    end
  end

  assign w_acc_next = w_frac ? w_frac_acc : w_acc_base;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_cen_p  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_acc    <= w_acc_next;
      r_cen_p  <= w_cen_p_next;
      r_active <= w_active_next;
    end
  end

  assign o_cen_p  = r_cen_p;
  assign o_active = r_active;

`ifdef MARIO_CEN_NEG_EN
  logic [ACC_W-1:0] w_half;
  logic             w_neg_hit;
  logic             r_cen_n;

  assign w_half    = i_den >> 1;
  // Half-period crossing either inside this period or just past the wrap.
  assign w_neg_hit = w_wrap ? (w_sum_sub >= {1'b0, w_half})
                            : ((r_acc < w_half) && (w_sum >= {1'b0, w_half}));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cen_n <= 1'b0;
    end else begin
      r_cen_n <= w_frac && w_neg_hit;
    end
  end

  assign o_cen_n = r_cen_n;
`else
  assign o_cen_n = 1'b0;
`endif

endmodule

// File: rtl/mario_cen_gen.sv
// Multi-channel fractional clock-enable generator on the 48 MHz master clock.
// Optional negative-phase outputs are enabled by defining MARIO_CEN_NEG_EN.
import mario_cen_pkg::*;

module mario_cen_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = CEN_ACC_W
) (
  input  logic          I_CLK_48M,
  input  logic          I_RESETn,
  mario_cen_if.slave    bus
);

  logic              w_en;
  logic              w_sync;
  logic [NUM_CH-1:0] w_cen_p;
  logic [NUM_CH-1:0] w_cen_n;
  logic [NUM_CH-1:0] w_active;

  assign w_en   = bus.I_EN;
  assign w_sync = bus.I_SYNC;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      mario_cen_chan #(
        .ACC_W (ACC_W)
      ) u_chan (
        .i_clk    (I_CLK_48M),
        .i_rst_n  (I_RESETn),
        .i_en     (w_en),
        .i_sync   (w_sync),
        .i_num    (bus.I_NUM[gi*ACC_W +: ACC_W]),
        .i_den    (bus.I_DEN[gi*ACC_W +: ACC_W]),
        .o_cen_p  (w_cen_p[gi]),
        .o_cen_n  (w_cen_n[gi]),
        .o_active (w_active[gi])
      );
    end
  endgenerate

  assign bus.O_CEN_P  = w_cen_p;
  assign bus.O_CEN_N  = w_cen_n;
  assign bus.O_ACTIVE = w_active;

endmodule

// File: tb/tb_mario_cen_gen.sv
// Directed self-checking bench for mario_cen_gen (4 channels, 8-bit accumulators).
module tb_mario_cen_gen;

  localparam int NCH = 4;
  localparam int AW  = 8;
`ifdef MARIO_CEN_NEG_EN
  localparam bit NEG_BUILT = 1'b1;
`else
  localparam bit NEG_BUILT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mario_cen_if #(.NUM_CH(NCH), .ACC_W(AW)) bus ();

  mario_cen_gen #(.NUM_CH(NCH), .ACC_W(AW)) dut (
    .I_CLK_48M (clk),
    .I_RESETn  (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int n, input int d);
    bus.I_NUM[k*AW +: AW] = n[AW-1:0];
    bus.I_DEN[k*AW +: AW] = d[AW-1:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.O_CEN_P !== 4'b0000) begin
      errors++;
      $display("FAIL reset_cen_p: got %b, want 0000", bus.O_CEN_P);
    end
    checks++;
    if (bus.O_CEN_N !== 4'b0000) begin
      errors++;
      $display("FAIL reset_cen_n: got %b, want 0000", bus.O_CEN_N);
    end
    checks++;
    if (bus.O_ACTIVE !== 4'b0000) begin
      errors++;
      $display("FAIL reset_active: got %b, want 0000", bus.O_ACTIVE);
    end
  endtask

  // ch0 1/4, ch1 11/48, ch2 DEN=0, ch3 NUM=0 all running from reset release.
  task automatic test_rates();
    int   p0_bad, n0_bad, p0_cnt, n0_cnt, p1_cnt, gap_bad, rep_bad, last1;
    int   ch2_bad, ch3_bad, act0_bad;
    logic hist1 [0:479];
    logic p_exp, n_exp;
    p0_bad = 0; n0_bad = 0; p0_cnt = 0; n0_cnt = 0; p1_cnt = 0;
    gap_bad = 0; rep_bad = 0; last1 = 0; ch2_bad = 0; ch3_bad = 0; act0_bad = 0;
    set_ch(0, 1, 4);
    set_ch(1, 11, 48);
    set_ch(2, 0, 0);
    set_ch(3, 0, 16);
    rst_n = 1'b1;
    for (int c = 1; c <= 480; c++) begin
      tick();
      if (c <= 64) begin
        p_exp = ((c % 4) == 0);
        n_exp = NEG_BUILT && ((c % 4) == 2);
        if (bus.O_CEN_P[0] !== p_exp) p0_bad++;
        if (bus.O_CEN_N[0] !== n_exp) n0_bad++;
        if (bus.O_CEN_P[0] === 1'b1) p0_cnt++;
        if (bus.O_CEN_N[0] === 1'b1) n0_cnt++;
      end
      if (bus.O_ACTIVE[0] !== 1'b1) act0_bad++;
      hist1[c-1] = bus.O_CEN_P[1];
      if (bus.O_CEN_P[1] === 1'b1) begin
        p1_cnt++;
        if (last1 > 0 && ((c - last1) < 4 || (c - last1) > 5)) gap_bad++;
        last1 = c;
      end
      if (bus.O_CEN_P[2] !== 1'b0 || bus.O_CEN_N[2] !== 1'b0 || bus.O_ACTIVE[2] !== 1'b0) ch2_bad++;
      if (bus.O_CEN_P[3] !== 1'b0 || bus.O_CEN_N[3] !== 1'b0) ch3_bad++;
    end
    for (int c = 48; c < 480; c++) begin
      if (hist1[c] !== hist1[c-48]) rep_bad++;
    end
    checks++;
    if (p0_bad != 0) begin errors++; $display("FAIL ch0_p_pattern: %0d cycles differ, want 0", p0_bad); end
    checks++;
    if (p0_cnt != 16) begin errors++; $display("FAIL ch0_p_count: got %0d, want 16", p0_cnt); end
    checks++;
    if (n0_bad != 0) begin errors++; $display("FAIL ch0_n_pattern: %0d cycles differ, want 0", n0_bad); end
    checks++;
    if (n0_cnt != (NEG_BUILT ? 16 : 0)) begin errors++; $display("FAIL ch0_n_count: got %0d, want %0d", n0_cnt, NEG_BUILT ? 16 : 0); end
    checks++;
    if (act0_bad != 0) begin errors++; $display("FAIL ch0_active: %0d cycles low, want 0", act0_bad); end
    checks++;
    if (p1_cnt != 110) begin errors++; $display("FAIL ch1_p_count: got %0d, want 110", p1_cnt); end
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL ch1_gaps: %0d gaps outside 4..5, want 0", gap_bad); end
    checks++;
    if (rep_bad != 0) begin errors++; $display("FAIL ch1_repeat48: %0d cycles differ, want 0", rep_bad); end
    checks++;
    if (ch2_bad != 0) begin errors++; $display("FAIL ch2_den0: %0d active/pulse cycles, want 0", ch2_bad); end
    checks++;
    if (ch3_bad != 0) begin errors++; $display("FAIL ch3_num0: %0d pulse cycles, want 0", ch3_bad); end
  endtask

  task automatic test_full_rate();
    int bad;
    bad = 0;
    set_ch(2, 5, 5);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.O_CEN_P[2] !== 1'b1 || bus.O_CEN_N[2] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ch2_full_rate: %0d bad cycles, want 0", bad); end
    checks++;
    if (bus.O_ACTIVE[2] !== 1'b1) begin errors++; $display("FAIL ch2_active: got %b, want 1", bus.O_ACTIVE[2]); end
  endtask

  task automatic test_sync();
    int bad;
    bad = 0;
    bus.I_SYNC = 1'b1;
    tick();
    bus.I_SYNC = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    bus.I_SYNC = 1'b1;
    tick();
    bus.I_SYNC = 1'b0;
    checks++;
    if (bus.O_CEN_P !== 4'b0000 || bus.O_CEN_N !== 4'b0000) begin
      errors++;
      $display("FAIL sync_outputs: got p=%b n=%b, want 0000/0000", bus.O_CEN_P, bus.O_CEN_N);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (bus.O_CEN_P[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sync_early_pulse: %0d early pulses, want 0", bad); end
    tick();
    checks++;
    if (bus.O_CEN_P[0] !== 1'b1) begin errors++; $display("FAIL sync_first_pulse: got %b, want 1", bus.O_CEN_P[0]); end
  endtask

  // 5 run cycles, 10 paused, 15 run: 20 enabled edges give 5 pulses.
  task automatic test_pause();
    int   bad, cnt, act_bad;
    logic p_exp;
    bad = 0; cnt = 0; act_bad = 0;
    bus.I_SYNC = 1'b1;
    tick();
    bus.I_SYNC = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      bus.I_EN = !(c >= 6 && c <= 15);
      tick();
      if (c <= 5)       p_exp = ((c % 4) == 0);
      else if (c <= 15) p_exp = 1'b0;
      else              p_exp = (((c - 10) % 4) == 0);
      if (bus.O_CEN_P[0] !== p_exp) bad++;
      if (bus.O_CEN_P[0] === 1'b1) cnt++;
      if (bus.O_ACTIVE[0] !== bus.I_EN) act_bad++;
    end
    bus.I_EN = 1'b1;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pause_pattern: %0d cycles differ, want 0", bad); end
    checks++;
    if (cnt != 5) begin errors++; $display("FAIL pause_count: got %0d, want 5", cnt); end
    checks++;
    if (act_bad != 0) begin errors++; $display("FAIL pause_active: %0d cycles differ, want 0", act_bad); end
  endtask

  task automatic test_async_reset();
    int bad;
    bad = 0;
    bus.I_SYNC = 1'b1;
    tick();
    bus.I_SYNC = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (bus.O_CEN_P[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_pulse: got %b, want 1", bus.O_CEN_P[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.O_CEN_P !== 4'b0000 || bus.O_CEN_N !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_pulse: got p=%b n=%b, want 0000/0000", bus.O_CEN_P, bus.O_CEN_N);
    end
    checks++;
    if (bus.O_ACTIVE !== 4'b0000) begin errors++; $display("FAIL async_reset_active: got %b, want 0000", bus.O_ACTIVE); end
    set_ch(3, 1, 16);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.O_CEN_P[3] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ch3_run16: %0d pulses, want 0", bad); end
    set_ch(3, 1, 3);
    tick();
    checks++;
    if (bus.O_CEN_P[3] !== 1'b1) begin errors++; $display("FAIL ch3_den_drop_pulse: got %b, want 1", bus.O_CEN_P[3]); end
    bad = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (bus.O_CEN_P[3] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ch3_after_drop: %0d pulses, want 0", bad); end
    tick();
    checks++;
    if (bus.O_CEN_P[3] !== 1'b1) begin errors++; $display("FAIL ch3_acc_cleared: got %b, want 1", bus.O_CEN_P[3]); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.I_EN    = 1'b1;
    bus.I_SYNC  = 1'b0;
    bus.I_NUM   = '0;
    bus.I_DEN   = '0;
    test_reset();
    test_rates();
    test_full_rate();
    test_sync();
    test_pause();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
